// File: rtl/serial_sub_nib_pkg.sv
// rtl/serial_sub_nib_pkg.sv - shared types and constants for the nibble-serial subtractor
package serial_sub_nib_pkg;

  localparam int NIB_W     = 4;
  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_sub_4.sv
// rtl/cla_sub_4.sv - combinational 4-bit lookahead-borrow subtractor
module cla_sub_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  // A position generates a borrow when it has 0 - 1, and passes an
  // incoming borrow straight through when both bits are equal.
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Every borrow is expanded from g/p and bin directly, so no stage waits on another.
  always_comb begin
    c[0] = bin;
    c[1] = g[0]
         | (p[0] & bin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & bin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & bin);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bin);
  end

  assign d    = a ^ b ^ c[3:0];
  assign bout = c[4];

endmodule

// File: rtl/serial_sub_nib.sv
// rtl/serial_sub_nib.sv - nibble-serial subtractor, optional signed overflow via SERIAL_SUB_OVF_EN
module serial_sub_nib
  import serial_sub_nib_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int NIBS  = W / NIB_W;
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

  state_t state;
  state_t state_nxt;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     d_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] d_nib;
  logic             bout_nib;
  logic             done;

  // The nibble under work is selected by the counter; the borrow register
  // carries the chain from one nibble to the next.
  assign a_nib = a_q[cnt*NIB_W +: NIB_W];
  assign b_nib = b_q[cnt*NIB_W +: NIB_W];

  cla_sub_4 u_cla_sub_4 (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (borrow_q),
    .d    (d_nib),
    .bout (bout_nib)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; in_valid only matters in IDLE, so
  // requests during RUN/DONE (including the consume edge) are dropped.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_NIB) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture at accept, then one nibble of difference per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            d_q      <= '0;
            borrow_q <= bin;
            cnt      <= '0;
          end
        end
        RUN: begin
          d_q[cnt*NIB_W +: NIB_W] <= d_nib;
          borrow_q                <= bout_nib;
          if (cnt != LAST_NIB) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Results are only visible in DONE so partial nibbles never leak out.
  assign done = (state == DONE);
  assign d    = done ? d_q : '0;
  assign bout = done & borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  assign ovf = done && (a_q[W-1] != b_q[W-1]) && (d_q[W-1] != a_q[W-1]);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_nib.sv
// tb/tb_serial_sub_nib.sv - self-checking bench for serial_sub_nib
module tb_serial_sub_nib;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_sub_nib #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // Reference arithmetic straight from the definition of a - b - bin.
  function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return x - y - W'(c);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return ({1'b0, x} < ({1'b0, y} + (W+1)'(c)));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] r;
    r = ref_d(x, y, c);
    return OVF_ON && (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Transaction-level model: 0 = waiting for operands, 1 = computing, 2 = holding result.
  int           m_phase;
  int           m_left;
  logic [W-1:0] m_d;
  logic         m_bout;
  logic         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_d     <= '0;
      m_bout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      if (m_phase == 0) begin
        if (in_valid) begin
          m_phase <= 1;
          m_left  <= W / 4;
          m_d     <= ref_d(a, b, bin);
          m_bout  <= ref_bout(a, b, bin);
          m_ovf   <= ref_ovf(a, b, bin);
        end
      end else if (m_phase == 1) begin
        if (m_left == 1) m_phase <= 2;
        else m_left <= m_left - 1;
      end else begin
        if (out_ready) m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_in_ready", in_ready, m_phase == 0);
    chk("cyc_out_valid", out_valid, m_phase == 2);
    chk("cyc_d", d, (m_phase == 2) ? m_d : '0);
    chk("cyc_bout", bout, (m_phase == 2) ? m_bout : 1'b0);
    chk("cyc_ovf", ovf, (m_phase == 2) ? m_ovf : 1'b0);
  end

  int lat;

  task automatic wait_result();
    lat = 0;
    while (!out_valid && lat < 32) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input string tag);
    @(posedge clk);
    #1;
    a = ia; b = ib; bin = ibin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    wait_result();
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, ovf, eo);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_consumed"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_d", d, 16'h0000);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "v1234");
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "vunder");
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, OVF_ON, "vsigned");
    run_op(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, "vripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "vallone");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, OVF_ON, "vposneg");

    // Result held under backpressure while new requests are ignored.
    @(posedge clk);
    #1;
    a = 16'h5555; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result();
    chk("bp_d0", d, 16'h4444);
    for (int i = 0; i < 3; i++) begin
      a = 16'hA000 + 16'(i); b = 16'h0F0F; bin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_d", d, 16'h4444);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    a = 16'h0010; b = 16'h0001; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_consumed", out_valid, 1'b0);
    chk("bp_ready_after", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accept", in_ready, 1'b0);
    wait_result();
    chk("bp_next_latency", lat, 4);
    chk("bp_next_d", d, 16'h000F);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Abort in the middle of RUN.
    a = 16'h1234; b = 16'h4321; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_d", d, 16'h0000);
    chk("abort_bout", bout, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", out_valid, 1'b0);
    end
    run_op(16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, "vpostrst");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_nib.md
SERIAL_SUB_NIB -- requirements
Module: serial_sub_nib

Interface
REQ-001 SHALL have parameter W, default 16, operand width; must be a multiple of 4, legal range 4..32.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands a, b, bin valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  minuend, unsigned or two's complement.
REQ-007 SHALL have port b  input  W  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port d  output  W  difference, a - b - bin mod 2^W.
REQ-012 SHALL have port bout  output  1  borrow-out, high when unsigned a < b + bin.
REQ-013 SHALL have port ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE: in_ready=1, out_valid=0; on a rising edge with in_valid=1, it SHALL capture a, b and bin, clear the nibble counter, and go to RUN.
REQ-016 In RUN: each edge SHALL compute one 4-bit nibble, LSB first, using lookahead borrow (generate ~a&b, propagate ~(a^b)), with the borrow chained from the previous nibble (bin for nibble 0).
REQ-017 RUN SHALL last exactly W/4 cycles; after the last nibble the FSM SHALL go to DONE.
REQ-018 Latency SHALL be W/4 cycles from the accept edge to the first cycle with out_valid=1 (4 cycles for W=16).
REQ-019 In DONE: out_valid=1 and in_ready=0; d, bout and ovf SHALL hold stable until out_valid and out_ready are both high on an edge, after which the FSM SHALL go to IDLE.
REQ-020 in_ready SHALL be 0 throughout RUN and DONE; in_valid SHALL be ignored there, with no queuing.
REQ-021 A new operation SHALL NOT be accepted in the cycle the result is consumed; the earliest accept is the following edge.
REQ-022 d, bout and ovf SHALL be 0 whenever out_valid=0 and SHALL NOT expose partial results.
REQ-023 Captured operands SHALL be immune to input changes after the accept edge.

Reset
REQ-024 Reset assertion SHALL immediately force IDLE, in_ready=1, out_valid=0, d=0, bout=0, ovf=0, and clear all internal registers.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no result emitted; the first accept after deassertion SHALL produce a correct result.

Configuration
REQ-026 With macro SERIAL_SUB_OVF_EN defined, ovf SHALL be (a[W-1]!=b[W-1]) && (d[W-1]!=a[W-1]), using the captured a and b, valid with out_valid.
REQ-027 Without SERIAL_SUB_OVF_EN, the ovf port SHALL still exist, be tied to 0, and have no overflow logic synthesized.

Structure
REQ-028 The shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE), NIB_W=4, and the default W.
REQ-029 SHALL instantiate one sub-module cla_sub_4: combinational 4-bit lookahead-borrow subtractor, ports a[3:0], b[3:0], bin, d[3:0], bout.

Verification
REQ-030 a=0x1234, b=0x0234, bin=0 -> d=0x1000, bout=0, ovf=0; out_valid rises exactly 4 cycles after accept.
REQ-031 a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0.
REQ-032 a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, bout=0; ovf=1 with SERIAL_SUB_OVF_EN, 0 without.
REQ-033 a=0x0100, b=0x0001, bin=1 -> d=0x00FE, bout=0 (borrow ripples across nibbles 0-1).
REQ-034 Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> d unchanged, in_ready=0, no second accept; result consumed on the first out_ready=1 edge, in_ready=1 on the next cycle.
REQ-035 Assert rst_n=0 two cycles into RUN -> outputs zero and in_ready=1 immediately; then a=0x00FF, b=0x00FF -> d=0x0000, bout=0.
